gmii_tx_framer: RTL and testbench
=================================

// Module: gmii_tx_framer
// PURPOSE
//  Ethernet MAC transmit framer. Turns a byte stream (valid/ready/last) into a GMII frame:
//  preamble, SFD, payload, zero padding to minimum length, CRC32 FCS and inter-frame gap.
//  Sits directly upstream of the GMII->RGMII DDR output stage; drives its gmii_txd/txen/txer.
// PARAMETERS
//  PREAMBLE_LEN  7   number of 0x55 bytes before SFD (1..15)
//  MIN_FRAME     60  min bytes (dst..payload, excl. FCS); shorter frames zero-padded; 0 = no pad
//  IFG_CYCLES    12  idle cycles (txen=0) forced after last FCS byte (>=1)
// PORTS
//  gmii_tx_clk   in   1  125 MHz GMII transmit clock; all logic on rising edge
//  reset         in   1  asynchronous, active-high reset
//  s_data        in   8  payload byte (first byte = dest MAC[47:40])
//  s_valid       in   1  s_data valid
//  s_last        in   1  s_data is final payload byte of frame
//  s_ready       out  1  byte accepted on edge where s_valid & s_ready
//  gmii_txd      out  8  GMII transmit data
//  gmii_txen     out  1  GMII transmit enable
//  gmii_txer     out  1  GMII transmit error
//  tx_busy       out  1  high in any state except IDLE
//  frame_done    out  1  1-cycle pulse on the cycle the last FCS byte is on gmii_txd
//  underflow     out  1  1-cycle pulse per cycle of payload starvation
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters/CRC cleared; frame in progress is abandoned
//   (txen drops immediately, no FCS, no IFG); new frame may start on first edge after release.
//  FSM: IDLE -> PREAMBLE -> SFD -> DATA -> [PAD] -> FCS -> IFG -> IDLE.
//   IDLE: s_valid sampled high -> PREAMBLE. s_ready=0.
//   PREAMBLE: PREAMBLE_LEN cycles, txd=0x55. SFD: 1 cycle, txd=0xD5.
//   DATA: s_ready=1 (comb. from state). Each handshake emits s_data, updates CRC, incr byte_cnt.
//    s_valid=0 in DATA = underflow: emit txd=0x00, txen=1, txer=1, pulse underflow, CRC and
//    byte_cnt unchanged, stay in DATA. Handshake with s_last: -> PAD if byte_cnt+1 < MIN_FRAME,
//    else -> FCS.
//   PAD: emit 0x00 through CRC until byte_cnt == MIN_FRAME, then -> FCS.
//   FCS: 4 cycles, ~crc bytes [7:0],[15:8],[23:16],[31:24]; frame_done on 4th.
//   IFG: IFG_CYCLES cycles txen=0, s_ready=0; s_valid ignored; then IDLE.
//  Outputs gmii_* registered: byte chosen by state at edge N appears after edge N+1.
//   s_valid high in IDLE at edge 0 -> first 0x55 on gmii_txd after edge 2; SFD after edge
//   PREAMBLE_LEN+2; first payload byte after edge PREAMBLE_LEN+3.
//  gmii_txen=1 from first preamble byte through last FCS byte inclusive; txd=0x00 when txen=0.
//  gmii_txer=1 only on underflow cycles.
//  CRC32: IEEE 802.3, reflected poly 0xEDB88320, init 0xFFFFFFFF, byte-wise LSB first,
//   covers payload + pad only; reset to init in SFD state.
//  byte_cnt: 11 bits, saturates at 2047 (used only for pad compare; no max-length check).
//  s_last on a byte with s_valid=0 is ignored. tx_busy = (state != IDLE).
// STRUCTURE
//  Package eth_tx_pkg: state enum (IDLE,PREAMBLE,SFD,DATA,PAD,FCS,IFG), ETH_PREAMBLE=8'h55,
//   ETH_SFD=8'hD5, CRC32_POLY_REFL=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF,
//   CRC32_RESIDUE=32'hDEBB20E3.
//  Sub-module crc32_d8: combinational next-CRC from (crc_in[31:0], data[7:0]); framer holds
//   the CRC register.
//  Output feeds the GMII->RGMII DDR stage with gmii_txer wired to its txer input.
// TESTING
//  1 MIN_FRAME=0, payload ASCII "123456789" -> gmii_txd after SFD: 31..39 then 26 39 F4 CB;
//    frame_done on CB; txen high for 7+1+9+4=21 cycles.
//  2 Default params, 14-byte payload -> 46 pad bytes 0x00; 60 bytes before FCS; FCS matches
//    bench CRC; receiver CRC over payload+pad+FCS = 0xDEBB20E3.
//  3 Back-to-back frames, s_valid held high -> exactly 12 txen=0 cycles between last FCS byte
//    and next 0x55; s_ready=0 throughout IFG.
//  4 Drop s_valid 3 cycles mid-payload -> 3 cycles txd=00/txen=1/txer=1, 3 underflow pulses,
//    FCS equals CRC of payload without gap bytes.
//  5 Assert reset during byte 20 of payload -> txen/txer/tx_busy 0 same cycle, no FCS; after
//    release, new frame starts cleanly with 7x 0x55, D5.
//  6 1500-byte payload with random s_valid gaps -> no pad, FCS correct, byte count 1500.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared state encoding and Ethernet/CRC32 constants for the GMII transmit framer
package eth_tx_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} tx_state_t;
    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: one byte step of the reflected IEEE 802.3 CRC32 (i_crc current, i_data byte LSB first, o_crc next)
module crc32_d8
    import eth_tx_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    always_comb begin
        o_crc = i_crc ^ {24'h0, i_data};
        for (int i = 0; i < 8; i++) o_crc = o_crc[0] ? (o_crc >> 1) ^ CRC32_POLY_REFL : o_crc >> 1;
    end
endmodule

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: valid/ready/last byte stream to GMII frame with preamble, SFD, pad, FCS and IFG
// gmii_tx_clk/reset: clock, async active-high reset; s_data/s_valid/s_last/s_ready: payload stream
// gmii_txd/gmii_txen/gmii_txer: GMII transmit; tx_busy: not idle; frame_done/underflow: status pulses
module gmii_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       gmii_tx_clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_txen,
    output logic       gmii_txer,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       underflow
);
    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    // the IDLE cycle before the next preamble supplies one idle cycle of the gap
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 2);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);

    tx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [10:0] r_byte_cnt;
    logic [31:0] r_crc;
    logic [7:0]  r_txd;
    logic        r_txen, r_txer, r_done, r_unf;
    logic [31:0] w_crc;
    logic [7:0]  w_crc_data;
    logic [10:0] w_cnt_inc;

    assign s_ready    = (r_state == DATA);
    assign tx_busy    = (r_state != IDLE);
    assign w_crc_data = (r_state == DATA) ? s_data : 8'h00;
    assign w_cnt_inc  = &r_byte_cnt ? r_byte_cnt : r_byte_cnt + 11'd1;

    crc32_d8 u_crc (.i_crc(r_crc), .i_data(w_crc_data), .o_crc(w_crc));

    // first pipeline stage: state machine picks the byte and its qualifiers
    always_ff @(posedge gmii_tx_clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_byte_cnt <= '0;
            r_crc      <= CRC32_INIT;
            r_txd      <= '0;
            r_txen     <= 1'b0;
            r_txer     <= 1'b0;
            r_done     <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_txd  <= 8'h00;
            r_txen <= 1'b0;
            r_txer <= 1'b0;
            r_done <= 1'b0;
            r_unf  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (s_valid) r_state <= PREAMBLE;
                end
                PREAMBLE: begin
                    r_txd  <= ETH_PREAMBLE;
                    r_txen <= 1'b1;
                    r_cnt  <= r_cnt + 16'd1;
                    if (r_cnt == PRE_LAST) r_state <= SFD;
                end
                SFD: begin
                    r_txd      <= ETH_SFD;
                    r_txen     <= 1'b1;
                    r_crc      <= CRC32_INIT;
                    r_byte_cnt <= '0;
                    r_state    <= DATA;
                end
                DATA: begin
                    r_txen <= 1'b1;
                    r_cnt  <= '0;
                    if (s_valid) begin
                        r_txd      <= s_data;
                        r_crc      <= w_crc;
                        r_byte_cnt <= w_cnt_inc;
                        if (s_last) r_state <= (w_cnt_inc < MIN_LEN) ? PAD : FCS;
                    end else begin
                        r_txer <= 1'b1;
                        r_unf  <= 1'b1;
                    end
                end
                PAD: begin
                    r_txen     <= 1'b1;
                    r_crc      <= w_crc;
                    r_byte_cnt <= w_cnt_inc;
                    if (w_cnt_inc == MIN_LEN) r_state <= FCS;
                end
                FCS: begin
                    r_txd  <= ~r_crc[{r_cnt[1:0], 3'b000} +: 8];
                    r_txen <= 1'b1;
                    r_cnt  <= r_cnt + 16'd1;
                    if (r_cnt[1:0] == 2'd3) begin
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= (IFG_CYCLES > 1) ? IFG : IDLE;
                    end
                end
                IFG: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt == IFG_LAST) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge gmii_tx_clk or posedge reset) begin
        if (reset) begin
            {gmii_txd, gmii_txen, gmii_txer, frame_done, underflow} <= '0;
        end else begin
            gmii_txd   <= r_txd;
            gmii_txen  <= r_txen;
            gmii_txer  <= r_txer;
            frame_done <= r_done;
            underflow  <= r_unf;
        end
    end
endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: directed self-checking bench for gmii_tx_framer
module tb_gmii_tx_framer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       sel_b = 1'b0;
    logic       a_ready, a_txen, a_txer, a_busy, a_done, a_unf;
    logic [7:0] a_txd;
    logic       b_ready, b_txen, b_txer, b_busy, b_done, b_unf;
    logic [7:0] b_txd;

    gmii_tx_framer u_a (
        .gmii_tx_clk(clk), .reset(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(a_ready), .gmii_txd(a_txd), .gmii_txen(a_txen), .gmii_txer(a_txer),
        .tx_busy(a_busy), .frame_done(a_done), .underflow(a_unf)
    );

    gmii_tx_framer #(.MIN_FRAME(0)) u_b (
        .gmii_tx_clk(clk), .reset(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(b_ready), .gmii_txd(b_txd), .gmii_txen(b_txen), .gmii_txer(b_txer),
        .tx_busy(b_busy), .frame_done(b_done), .underflow(b_unf)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gaps = 0;
    logic [7:0] pay [2048];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // monitor for the default-parameter instance; txer bytes are kept out of the frame image
    logic [7:0] fa[$], la[$];
    int na, a_er, a_un, a_idle, a_gap, a_rdy_gap, a_bad0;
    logic a_prev;
    always @(negedge clk) begin
        if (rst) begin
            fa.delete();
            {na, a_er, a_un, a_idle, a_gap, a_rdy_gap, a_bad0} = '0;
            a_prev = 1'b0;
        end else begin
            if (a_txen && !a_txer) fa.push_back(a_txd);
            if (a_txer && a_txd != 8'h00) a_bad0++;
            if (!a_txen && a_txd != 8'h00) a_bad0++;
            if (a_txer) a_er++;
            if (a_unf) a_un++;
            if (!a_txen && a_ready) a_rdy_gap++;
            if (a_txen && !a_prev) a_gap = a_idle;
            a_idle = a_txen ? 0 : a_idle + 1;
            if (a_done) begin
                la = fa;
                fa.delete();
                na++;
            end
            a_prev = a_txen;
        end
    end

    // monitor for the no-padding instance
    logic [7:0] fb[$], lb[$];
    logic [7:0] b_done_byte;
    int nb, b_rise;
    logic b_prev;
    always @(negedge clk) begin
        if (rst) begin
            fb.delete();
            nb = 0;
            b_rise = 0;
            b_prev = 1'b0;
            b_done_byte = 8'h00;
        end else begin
            if (b_txen) fb.push_back(b_txd);
            if (b_txen && !b_prev) b_rise = cyc;
            if (b_done) begin
                lb = fb;
                fb.delete();
                nb++;
                b_done_byte = b_txd;
            end
            b_prev = b_txen;
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // drives pay[0..n-1]; split ends an extra frame early, gaps starve the DATA state
    task automatic send(input int n, input int split, input int gap_at, input int gap_len,
                        input bit rnd, input int rst_at);
        int i = 0, g = 0, t = 0;
        logic r, gap;
        gaps = 0;
        while (i < n && t < 20000) begin
            r = sel_b ? b_ready : a_ready;
            gap = r && ((i == gap_at && g < gap_len) || (rnd && $urandom_range(0, 3) == 0));
            if (gap) begin
                g++;
                gaps++;
            end
            s_valid = !gap;
            s_data = gap ? 8'hEE : pay[i];
            s_last = gap || i == n - 1 || i == split - 1;
            @(posedge clk);
            t++;
            if (s_valid && r) i++;
            #1;
            if (i == rst_at) begin
                rst = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        check("send_budget", 32'(t < 20000), 32'd1);
    endtask

    task automatic wait_done(input int ta, input int tb);
        int t = 0;
        while ((na < ta || nb < tb) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("done_budget", 32'(t < 5000), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] f[$], input int off,
                               input int n, input int minf);
        int body = (n < minf) ? minf : n;
        int bad_pre = 0, bad_body = 0, b;
        logic [31:0] c = 32'hFFFFFFFF;
        logic [31:0] r;
        logic [7:0] e;
        check({tag, "_len"}, 32'(f.size()), 32'(8 + body + 4));
        if (f.size() != 8 + body + 4) return;
        for (int i = 0; i < 7; i++) if (f[i] != 8'h55) bad_pre++;
        check({tag, "_preamble"}, 32'(bad_pre), 32'd0);
        check({tag, "_sfd"}, {24'h0, f[7]}, 32'hD5);
        for (int i = 0; i < body; i++) begin
            e = (i < n) ? pay[off + i] : 8'h00;
            if (f[8 + i] != e) bad_body++;
            c = crc_upd(c, e);
        end
        check({tag, "_body"}, 32'(bad_body), 32'd0);
        b = 8 + body;
        check({tag, "_fcs"}, {f[b + 3], f[b + 2], f[b + 1], f[b]}, ~c);
        r = c;
        for (int i = 0; i < 4; i++) r = crc_upd(r, f[b + i]);
        check({tag, "_residue"}, r, 32'hDEBB20E3);
    endtask

    int c0, bad;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_txd", {24'h0, a_txd}, 32'h0);
        check("rst_txen", {31'h0, a_txen}, 32'h0);
        check("rst_txer", {31'h0, a_txer}, 32'h0);
        check("rst_busy", {31'h0, a_busy}, 32'h0);
        check("rst_ready", {31'h0, a_ready}, 32'h0);
        check("rst_done", {31'h0, a_done}, 32'h0);
        check("rst_unf", {31'h0, a_unf}, 32'h0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // "123456789" without padding: known check value 0xCBF43926
        sel_b = 1'b1;
        for (int i = 0; i < 9; i++) pay[i] = 8'(8'h31 + i);
        c0 = cyc;
        send(9, -1, -1, 0, 1'b0, -1);
        wait_done(0, 1);
        check("t1_len", 32'(lb.size()), 32'd21);
        check("t1_first_55", 32'(b_rise), 32'(c0 + 3));
        check("t1_sfd", {24'h0, lb[7]}, 32'hD5);
        bad = 0;
        for (int i = 0; i < 9; i++) if (lb[8 + i] != 8'(8'h31 + i)) bad++;
        check("t1_payload", 32'(bad), 32'd0);
        check("t1_fcs", {lb[20], lb[19], lb[18], lb[17]}, 32'hCBF43926);
        check("t1_done_byte", {24'h0, b_done_byte}, 32'hCB);

        // short frame padded to 60 bytes
        sel_b = 1'b0;
        do_reset();
        for (int i = 0; i < 14; i++) pay[i] = 8'(i * 7 + 3);
        send(14, -1, -1, 0, 1'b0, -1);
        wait_done(1, 0);
        check_frame("t2", la, 0, 14, 60);

        // back-to-back frames with s_valid held high through the gap
        do_reset();
        for (int i = 0; i < 28; i++) pay[i] = 8'(i * 13 + 1);
        send(28, 14, -1, 0, 1'b0, -1);
        wait_done(2, 0);
        check("t3_ifg", 32'(a_gap), 32'd12);
        check("t3_ready_in_gap", 32'(a_rdy_gap), 32'd0);
        check_frame("t3", la, 14, 14, 60);

        // three starved cycles mid-payload, with s_last asserted on the idle bytes
        do_reset();
        for (int i = 0; i < 20; i++) pay[i] = 8'(8'hC0 ^ i);
        send(20, -1, 5, 3, 1'b0, -1);
        wait_done(1, 0);
        check("t4_underflow", 32'(a_un), 32'd3);
        check("t4_txer", 32'(a_er), 32'd3);
        check("t4_zero_bytes", 32'(a_bad0), 32'd0);
        check_frame("t4", la, 0, 20, 60);

        // reset during payload abandons the frame
        do_reset();
        for (int i = 0; i < 40; i++) pay[i] = 8'(i + 8'h40);
        send(40, -1, -1, 0, 1'b0, 20);
        #1;
        check("t5_txen", {31'h0, a_txen}, 32'h0);
        check("t5_txer", {31'h0, a_txer}, 32'h0);
        check("t5_busy", {31'h0, a_busy}, 32'h0);
        check("t5_txd", {24'h0, a_txd}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t5_no_tail", 32'(fa.size()), 32'd0);
        check("t5_no_done", 32'(na), 32'd0);
        for (int i = 0; i < 10; i++) pay[i] = 8'(8'hA5 + i * 3);
        send(10, -1, -1, 0, 1'b0, -1);
        wait_done(1, 0);
        check_frame("t5", la, 0, 10, 60);

        // long frame with random starvation
        do_reset();
        for (int i = 0; i < 1500; i++) pay[i] = 8'($urandom_range(0, 255));
        send(1500, -1, -1, 0, 1'b1, -1);
        wait_done(1, 0);
        check_frame("t6", la, 0, 1500, 60);
        check("t6_underflow", 32'(a_un), 32'(gaps));
        check("t6_txer", 32'(a_er), 32'(gaps));
        check("t6_zero_bytes", 32'(a_bad0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
